// File: rtl/control_sequencer_pkg.sv
// Shared types and constants for the control sequencer: state enum, opcode and ALU code tables,
// IR field positions and the strobe bundle.
package cu_pkg;

  localparam int IRW  = 32;
  localparam int OPW  = 5;
  localparam int ALUW = 5;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  typedef enum logic [2:0] {
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_HALT
  } cu_state_e;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  localparam logic [ALUW-1:0] ALU_ADD = 5'b00010;
  localparam logic [ALUW-1:0] ALU_SUB = 5'b00011;
  localparam logic [ALUW-1:0] ALU_AND = 5'b00001;
  localparam logic [ALUW-1:0] ALU_OR  = 5'b00100;

  typedef struct packed {
    logic PCout;
    logic ZLOout;
    logic MDRout;
    logic MARin;
    logic Zin;
    logic PCin;
    logic MDRin;
    logic IRin;
    logic Yin;
    logic IncrementPC;
    logic Read;
    logic Gra;
    logic Grb;
    logic Grc;
    logic Rin;
    logic Rout;
  } cu_strobes_t;

  function automatic logic [OPW-1:0] ir_opc(input logic [IRW-1:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control-unit <-> datapath signal bundle. master = control unit, slave = datapath side.
interface control_sequencer_if;
  import cu_pkg::*;

  // No valid/ready pair: every strobe is a level held for the whole cycle and sampled by the
  // datapath on the next rising edge; MemReady acts as the ready for the T1 memory read.
  logic [IRW-1:0]  IR;
  logic            Stop;
  logic            MemReady;
  logic            Run;
  logic            PCout, ZLOout, MDRout;
  logic            MARin, Zin, PCin, MDRin, IRin, Yin;
  logic            IncrementPC, Read;
  logic            Gra, Grb, Grc, Rin, Rout;
  logic [ALUW-1:0] ALUControl;
  cu_state_e       state;

  modport master (
    input  IR, Stop, MemReady,
    output Run, PCout, ZLOout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
           IncrementPC, Read, Gra, Grb, Grc, Rin, Rout, ALUControl, state
  );

  modport slave (
    output IR, Stop, MemReady,
    input  Run, PCout, ZLOout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
           IncrementPC, Read, Gra, Grb, Grc, Rin, Rout, ALUControl, state
  );
endinterface

// File: rtl/control_sequencer_op_decode.sv
// Combinational opcode classifier: IR[31:27] -> {is_alu, is_nop, is_halt, alu_code}.
// Unlisted opcodes are treated as NOP.
module cu_op_decode
  import cu_pkg::*;
(
  input  logic [OPW-1:0]  opc_i,
  output logic            is_alu_o,
  output logic            is_nop_o,
  output logic            is_halt_o,
  output logic [ALUW-1:0] alu_code_o
);

  always_comb begin
    is_alu_o   = 1'b0;
    is_nop_o   = 1'b1;
    is_halt_o  = 1'b0;
    alu_code_o = '0;
    case (opc_i)
      OP_ADD:  begin is_alu_o = 1'b1; is_nop_o = 1'b0; alu_code_o = ALU_ADD; end
      OP_SUB:  begin is_alu_o = 1'b1; is_nop_o = 1'b0; alu_code_o = ALU_SUB; end
      OP_AND:  begin is_alu_o = 1'b1; is_nop_o = 1'b0; alu_code_o = ALU_AND; end
      OP_OR:   begin is_alu_o = 1'b1; is_nop_o = 1'b0; alu_code_o = ALU_OR;  end
      OP_HALT: begin is_halt_o = 1'b1; is_nop_o = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit for the phase-1 datapath (fetch T0-T2, ALU execute T3-T5).
// Optional feature: CU_MEM_WAIT_EN holds T1 until MemReady is seen.
module control_sequencer
  import cu_pkg::*;
(
  input  logic                Clock,
  input  logic                Resetn,
  control_sequencer_if.master bus
);

  cu_state_e       state_q;
  logic            stop_pend_q;
  logic            t1_wait;
  logic            is_alu, is_nop, is_halt;
  logic [ALUW-1:0] alu_code;
  logic            halt_req;
  cu_strobes_t     strb;
  cu_strobes_t     strb_g;
  logic [ALUW-1:0] alu_ctl;

  cu_op_decode u_dec (
    .opc_i      (ir_opc(bus.IR)),
    .is_alu_o   (is_alu),
    .is_nop_o   (is_nop),
    .is_halt_o  (is_halt),
    .alu_code_o (alu_code)
  );

  // Stop is latched so a request seen mid-instruction still halts at the instruction boundary.
  assign halt_req = bus.Stop | stop_pend_q;

`ifdef CU_MEM_WAIT_EN
  logic t1_wait_q;
  logic unused_bits;
  assign t1_wait     = t1_wait_q;
  assign unused_bits = ^bus.IR[OPC_LSB-1:0];
`else
  logic unused_bits;
  assign t1_wait     = 1'b0;
  assign unused_bits = ^{bus.MemReady, bus.IR[OPC_LSB-1:0]};
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_T0;
      stop_pend_q <= 1'b0;
`ifdef CU_MEM_WAIT_EN
      t1_wait_q   <= 1'b0;
`endif
    end else begin
      if (state_q != S_HALT) stop_pend_q <= halt_req;
      case (state_q)
        S_T0: state_q <= S_T1;
        S_T1: begin
`ifdef CU_MEM_WAIT_EN
          if (bus.MemReady) begin
            state_q   <= S_T2;
            t1_wait_q <= 1'b0;
          end else begin
            t1_wait_q <= 1'b1;
          end
`else
          state_q <= S_T2;
`endif
        end
        S_T2: state_q <= S_T3;
        S_T3: begin
          if (is_alu)      state_q <= S_T4;
          else if (is_nop) state_q <= halt_req ? S_HALT : S_T0;
          else             state_q <= S_HALT;
        end
        S_T4: state_q <= S_T5;
        S_T5: state_q <= halt_req ? S_HALT : S_T0;
        default: state_q <= S_HALT;
      endcase
    end
  end

  always_comb begin
    strb    = '0;
    alu_ctl = '0;
    case (state_q)
      S_T0: begin
        strb.PCout = 1'b1; strb.MARin = 1'b1; strb.IncrementPC = 1'b1; strb.Zin = 1'b1;
      end
      S_T1: begin
        strb.Read   = 1'b1;
        strb.MDRin  = 1'b1;
        strb.ZLOout = !t1_wait;
        strb.PCin   = !t1_wait;
      end
      S_T2: begin
        strb.MDRout = 1'b1; strb.IRin = 1'b1;
      end
      S_T3: begin
        strb.Grb = is_alu; strb.Rout = is_alu; strb.Yin = is_alu;
      end
      S_T4: begin
        strb.Grc = 1'b1; strb.Rout = 1'b1; strb.Zin = 1'b1;
        alu_ctl  = alu_code;
      end
      S_T5: begin
        strb.ZLOout = 1'b1; strb.Gra = 1'b1; strb.Rin = 1'b1;
      end
      default: ;
    endcase
  end

  // Gating with Resetn clears the strobes the instant reset asserts, independent of the clock.
  assign strb_g = Resetn ? strb : '0;

  assign bus.Run         = (state_q != S_HALT);
  assign bus.ALUControl  = Resetn ? alu_ctl : '0;
  assign bus.state       = state_q;
  assign bus.PCout       = strb_g.PCout;
  assign bus.ZLOout      = strb_g.ZLOout;
  assign bus.MDRout      = strb_g.MDRout;
  assign bus.MARin       = strb_g.MARin;
  assign bus.Zin         = strb_g.Zin;
  assign bus.PCin        = strb_g.PCin;
  assign bus.MDRin       = strb_g.MDRin;
  assign bus.IRin        = strb_g.IRin;
  assign bus.Yin         = strb_g.Yin;
  assign bus.IncrementPC = strb_g.IncrementPC;
  assign bus.Read        = strb_g.Read;
  assign bus.Gra         = strb_g.Gra;
  assign bus.Grb         = strb_g.Grb;
  assign bus.Grc         = strb_g.Grc;
  assign bus.Rin         = strb_g.Rin;
  assign bus.Rout        = strb_g.Rout;

  a_bus_onehot: assert property (@(posedge Clock) disable iff (!Resetn)
    $onehot0({bus.PCout, bus.ZLOout, bus.MDRout, bus.Rout}))
    else $error("bus driver contention");

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: table-driven instruction vectors, a random instruction stream,
// and hand-written reset / halt sequences, all checked against a per-cycle expected queue.
module tb_control_sequencer;

`ifdef CU_MEM_WAIT_EN
  localparam bit MW = 1'b1;
`else
  localparam bit MW = 1'b0;
`endif

  localparam int W = 22;

  localparam logic [15:0] X_PCOUT  = 16'h8000;
  localparam logic [15:0] X_ZLOOUT = 16'h4000;
  localparam logic [15:0] X_MDROUT = 16'h2000;
  localparam logic [15:0] X_MARIN  = 16'h1000;
  localparam logic [15:0] X_ZIN    = 16'h0800;
  localparam logic [15:0] X_PCIN   = 16'h0400;
  localparam logic [15:0] X_MDRIN  = 16'h0200;
  localparam logic [15:0] X_IRIN   = 16'h0100;
  localparam logic [15:0] X_YIN    = 16'h0080;
  localparam logic [15:0] X_INCPC  = 16'h0040;
  localparam logic [15:0] X_READ   = 16'h0020;
  localparam logic [15:0] X_GRA    = 16'h0010;
  localparam logic [15:0] X_GRB    = 16'h0008;
  localparam logic [15:0] X_GRC    = 16'h0004;
  localparam logic [15:0] X_RIN    = 16'h0002;
  localparam logic [15:0] X_ROUT   = 16'h0001;

  logic Clock;
  logic Resetn;
  int   checks;
  int   errors;

  control_sequencer_if bus();

  control_sequencer dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] mk(input logic run, input logic [4:0] alu, input logic [15:0] s);
    return {run, alu, s};
  endfunction

  function automatic logic [W-1:0] sample();
    return {bus.Run, bus.ALUControl,
            bus.PCout, bus.ZLOout, bus.MDRout, bus.MARin, bus.Zin, bus.PCin, bus.MDRin, bus.IRin,
            bus.Yin, bus.IncrementPC, bus.Read, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout};
  endfunction

  function automatic logic [4:0] alu_of(input logic [4:0] opc);
    case (opc)
      5'b00011: return 5'b00010;
      5'b00100: return 5'b00011;
      5'b00101: return 5'b00001;
      5'b00110: return 5'b00100;
      default:  return 5'b00000;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left at posedge+1: drives the cycle's inputs, samples at the negedge.
  task automatic do_cycle(input logic mr, input logic st, output logic [W-1:0] got);
    bus.MemReady = mr;
    bus.Stop     = st;
    @(negedge Clock);
    got = sample();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Resetn       = 1'b0;
    bus.Stop     = 1'b0;
    bus.MemReady = 1'b0;
    #1;
    check("reset_state", sample(), mk(1'b1, 5'd0, 16'h0000));
    repeat (2) @(posedge Clock);
    #1;
    Resetn = 1'b1;
  endtask

  // Scoreboard: builds the expected cycle-by-cycle outputs of one instruction, then replays it.
  task automatic run_instr(input logic [31:0] ir, input logic [4:0] alu, input int wait_n,
                           input bit stop, input string tag);
    logic [W-1:0] exp_q[$];
    logic [1:0]   in_q[$];
    logic [W-1:0] got;
    logic [W-1:0] exp;
    logic [1:0]   inp;
    logic [4:0]   opc;
    bit           is_alu, is_halt, halts;
    int           pcin_cnt, read_cnt;
    opc     = ir[31:27];
    is_alu  = (opc == 5'b00011) || (opc == 5'b00100) || (opc == 5'b00101) || (opc == 5'b00110);
    is_halt = (opc == 5'b11011);
    halts   = is_halt || stop;

    exp_q.push_back(mk(1, 0, X_PCOUT | X_MARIN | X_INCPC | X_ZIN));      in_q.push_back(2'b10);
    exp_q.push_back(mk(1, 0, X_ZLOOUT | X_PCIN | X_READ | X_MDRIN));     in_q.push_back({wait_n == 0, 1'b0});
    if (MW) for (int i = 1; i <= wait_n; i++) begin
      exp_q.push_back(mk(1, 0, X_READ | X_MDRIN));                       in_q.push_back({i == wait_n, 1'b0});
    end
    exp_q.push_back(mk(1, 0, X_MDROUT | X_IRIN));                        in_q.push_back({1'b1, stop});
    exp_q.push_back(mk(1, 0, is_alu ? (X_GRB | X_ROUT | X_YIN) : 16'h0)); in_q.push_back({1'b1, stop});
    if (is_alu) begin
      exp_q.push_back(mk(1, alu, X_GRC | X_ROUT | X_ZIN));               in_q.push_back({1'b1, stop});
      exp_q.push_back(mk(1, 0, X_ZLOOUT | X_GRA | X_RIN));               in_q.push_back({1'b1, stop});
    end
    if (halts) for (int i = 0; i < 20; i++) begin
      exp_q.push_back(mk(0, 0, 16'h0));                                  in_q.push_back({1'b1, stop});
    end

    bus.IR   = ir;
    pcin_cnt = 0;
    read_cnt = 0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      inp = in_q.pop_front();
      do_cycle(inp[1], inp[0], got);
      check(tag, got, exp);
      check({tag, "_bus_onehot"}, W'($countones({got[15], got[14], got[13], got[0]}) <= 1), W'(1));
      if (got[10]) pcin_cnt++;
      if (got[5])  read_cnt++;
    end
    check({tag, "_pcin_pulses"}, W'(pcin_cnt), W'(1));
    check({tag, "_read_cycles"}, W'(read_cnt), W'(1 + (MW ? wait_n : 0)));
    if (halts) do_reset();
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [31:0] ir;
    logic [4:0]  exp_alu;
    int          wait_n;
    bit          stop;
    string       name;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [W-1:0] got;
    logic [4:0]   opc;
    int           r;
    checks       = 0;
    errors       = 0;
    bus.IR       = 32'h0;
    bus.Stop     = 1'b0;
    bus.MemReady = 1'b0;

    vecs[0]  = '{32'h28228000, 5'b00001, 0, 1'b0, "and_r0_r4_r5"};
    vecs[1]  = '{32'h18228000, 5'b00010, 0, 1'b0, "add"};
    vecs[2]  = '{32'h20228000, 5'b00011, 0, 1'b0, "sub"};
    vecs[3]  = '{32'h30228000, 5'b00100, 0, 1'b0, "or"};
    vecs[4]  = '{32'hD0000000, 5'b00000, 0, 1'b0, "nop"};
    vecs[5]  = '{32'hF8123456, 5'b00000, 0, 1'b0, "unlisted"};
    vecs[6]  = '{32'h30228000, 5'b00100, 3, 1'b0, "or_memwait3"};
    vecs[7]  = '{32'hD0000000, 5'b00000, 3, 1'b0, "nop_memwait3"};
    vecs[8]  = '{32'h20228000, 5'b00011, 1, 1'b0, "sub_memwait1"};
    vecs[9]  = '{32'h18228000, 5'b00010, 0, 1'b1, "add_stop"};
    vecs[10] = '{32'hD8000000, 5'b00000, 0, 1'b0, "halt_op"};
    vecs[11] = '{32'hD0000000, 5'b00000, 0, 1'b1, "nop_stop"};

    do_reset();

    for (int i = 0; i < 12; i++)
      run_instr(vecs[i].ir, vecs[i].exp_alu, vecs[i].wait_n, vecs[i].stop, vecs[i].name);

    // Asynchronous reset in the middle of T4.
    bus.IR = 32'h20228000;
    do_cycle(1'b1, 1'b0, got); check("midT4_t0", got, mk(1, 0, X_PCOUT | X_MARIN | X_INCPC | X_ZIN));
    do_cycle(1'b1, 1'b0, got); check("midT4_t1", got, mk(1, 0, X_ZLOOUT | X_PCIN | X_READ | X_MDRIN));
    do_cycle(1'b1, 1'b0, got); check("midT4_t2", got, mk(1, 0, X_MDROUT | X_IRIN));
    do_cycle(1'b1, 1'b0, got); check("midT4_t3", got, mk(1, 0, X_GRB | X_ROUT | X_YIN));
    @(negedge Clock);
    check("midT4_t4", sample(), mk(1, 5'b00011, X_GRC | X_ROUT | X_ZIN));
    #1 Resetn = 1'b0;
    #1 check("midT4_async_clear", sample(), mk(1, 0, 16'h0));
    @(posedge Clock);
    #1 Resetn = 1'b1;
    run_instr(32'h28228000, 5'b00001, 0, 1'b0, "after_midT4_reset");

    // Random instruction stream.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: opc = 5'b00011;
        1: opc = 5'b00100;
        2: opc = 5'b00101;
        3: opc = 5'b00110;
        4: opc = 5'b11010;
        default: opc = 5'($urandom_range(0, 31));
      endcase
      run_instr({opc, 27'($urandom)}, alu_of(opc), $urandom_range(0, 3),
                $urandom_range(0, 9) == 0, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
